// File: rtl/uart_boot_loader_if.sv
// Signal bundle between the boot loader and its UART, imem and core neighbours.
// The master side is the boot loader, and the slave side is the surrounding CPU top.
interface uart_boot_loader_if #(
    parameter int IMEM_ADDR_W = 16
);
    logic [7:0]             rx_rdata;
    logic                   rx_rdata_ready;
    logic                   rx_ferr;
    logic [7:0]             tx_sdata;
    logic                   tx_start;
    logic                   tx_busy;
    logic                   imem_we;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [31:0]            imem_wdata;
    logic                   boot_done;
    logic                   boot_err;
    logic                   cpu_tx_req;
    logic [7:0]             cpu_tx_data;
    logic                   cpu_tx_ack;
    logic                   cpu_rx_valid;
    logic [7:0]             cpu_rx_data;

    modport master (
        input  rx_rdata, rx_rdata_ready, rx_ferr, tx_busy, cpu_tx_req, cpu_tx_data,
        output tx_sdata, tx_start, imem_we, imem_addr, imem_wdata,
               boot_done, boot_err, cpu_tx_ack, cpu_rx_valid, cpu_rx_data
    );

    modport slave (
        output rx_rdata, rx_rdata_ready, rx_ferr, tx_busy, cpu_tx_req, cpu_tx_data,
        input  tx_sdata, tx_start, imem_we, imem_addr, imem_wdata,
               boot_done, boot_err, cpu_tx_ack, cpu_rx_valid, cpu_rx_data
    );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot sequencer: handshakes with the host, loads the program image into imem,
// then releases the core and shares the UART between the core and stdin.
module uart_boot_loader #(
    parameter int IMEM_ADDR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_boot_loader_if.master bus
);
    localparam logic [63:0]          MAX_BYTES = 64'd4 << IMEM_ADDR_W;
    localparam logic [IMEM_ADDR_W:0] ONE_WORD  = 1;

    typedef enum logic [2:0] {
        S_SEND_99,
        S_RECV_SIZE,
        S_RECV_PROG,
        S_SEND_AA,
        S_RUN,
        S_ERROR
    } state_t;

    state_t state_q, state_d;

    logic                   guard_q;
    logic                   tx_start_q;
    logic [7:0]             tx_sdata_q;
    logic [1:0]             byte_cnt_q;
    logic [23:0]            shreg_q;
    logic [IMEM_ADDR_W:0]   word_idx_q;
    logic [IMEM_ADDR_W:0]   words_total_q;
    logic                   imem_we_q;
    logic [IMEM_ADDR_W-1:0] imem_addr_q;
    logic [31:0]            imem_wdata_q;
    logic                   cpu_tx_ack_q;
    logic                   cpu_rx_valid_q;
    logic [7:0]             cpu_rx_data_q;

    logic        rx_ok, rx_bad, tx_free, last_byte, prog_open, size_bad;
    logic [31:0] assembled;

    logic        issue, ack_d, rx_fwd, take_size, take_prog;
    logic [7:0]  issue_byte;

    assign rx_ok     = bus.rx_rdata_ready & ~bus.rx_ferr;
    assign rx_bad    = bus.rx_rdata_ready & bus.rx_ferr;
    // tx_busy rises one cycle after tx_start, so guard covers that gap.
    assign tx_free   = ~bus.tx_busy & ~guard_q;
    assign last_byte = (byte_cnt_q == 2'd3);
    // Incoming byte lands on top, so after four bytes the word is little-endian.
    assign assembled = {bus.rx_rdata, shreg_q};
    assign size_bad  = (assembled[1:0] != 2'b00) || ({32'd0, assembled} > MAX_BYTES);
    assign prog_open = (word_idx_q != words_total_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_SEND_99;
        end else begin
            // NOTE: sequential state always uses <= so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_SEND_99:   if (tx_free) state_d = S_RECV_SIZE;
            S_RECV_SIZE: begin
                if (rx_bad) begin
                    state_d = S_ERROR;
                end else if (rx_ok && last_byte) begin
                    if (assembled == 32'd0) state_d = S_SEND_AA;
                    else if (size_bad)      state_d = S_ERROR;
                    else                    state_d = S_RECV_PROG;
                end
            end
            S_RECV_PROG: begin
                if (rx_bad)                       state_d = S_ERROR;
                else if (imem_we_q && !prog_open) state_d = S_SEND_AA;
            end
            S_SEND_AA:   if (tx_free) state_d = S_RUN;
            S_RUN:       state_d = S_RUN;
            S_ERROR:     state_d = S_ERROR;
            default:     state_d = S_ERROR;
        endcase
    end

    always_comb begin
        issue      = 1'b0;
        issue_byte = 8'h00;
        ack_d      = 1'b0;
        rx_fwd     = 1'b0;
        take_size  = 1'b0;
        take_prog  = 1'b0;
        case (state_q)
            S_SEND_99: begin
                issue      = tx_free;
                issue_byte = 8'h99;
            end
            S_RECV_SIZE: take_size = rx_ok;
            S_RECV_PROG: take_prog = rx_ok & prog_open;
            S_SEND_AA: begin
                issue      = tx_free;
                issue_byte = 8'hAA;
            end
            S_RUN: begin
                issue      = tx_free & bus.cpu_tx_req;
                issue_byte = bus.cpu_tx_data;
                ack_d      = issue;
                rx_fwd     = rx_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            guard_q        <= 1'b0;
            tx_start_q     <= 1'b0;
            tx_sdata_q     <= 8'h00;
            byte_cnt_q     <= 2'd0;
            shreg_q        <= 24'd0;
            word_idx_q     <= '0;
            words_total_q  <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= 32'd0;
            cpu_tx_ack_q   <= 1'b0;
            cpu_rx_valid_q <= 1'b0;
            cpu_rx_data_q  <= 8'h00;
        end else begin
            guard_q        <= issue;
            tx_start_q     <= issue;
            cpu_tx_ack_q   <= ack_d;
            cpu_rx_valid_q <= rx_fwd;
            imem_we_q      <= 1'b0;
            if (issue)  tx_sdata_q    <= issue_byte;
            if (rx_fwd) cpu_rx_data_q <= bus.rx_rdata;
            if (take_size || take_prog) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                shreg_q    <= assembled[31:8];
            end
            if (take_size && last_byte) words_total_q <= assembled[IMEM_ADDR_W+2:2];
            if (take_prog && last_byte) begin
                imem_we_q    <= 1'b1;
                imem_wdata_q <= assembled;
                imem_addr_q  <= word_idx_q[IMEM_ADDR_W-1:0];
                word_idx_q   <= word_idx_q + ONE_WORD;
            end
        end
    end

    assign bus.tx_sdata     = tx_sdata_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.imem_we      = imem_we_q;
    assign bus.imem_addr    = imem_addr_q;
    assign bus.imem_wdata   = imem_wdata_q;
    assign bus.boot_done    = (state_q == S_RUN);
    assign bus.boot_err     = (state_q == S_ERROR);
    assign bus.cpu_tx_ack   = cpu_tx_ack_q;
    assign bus.cpu_rx_valid = cpu_rx_valid_q;
    assign bus.cpu_rx_data  = cpu_rx_data_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table of boot scenarios plus
// hand-written RUN-mode TX/RX and mid-load reset sequences.
module tb_uart_boot_loader;
    localparam int W    = 16;
    localparam int BUSY = 6;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    uart_boot_loader_if #(.IMEM_ADDR_W(W)) bus ();
    uart_boot_loader #(.IMEM_ADDR_W(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        string       name;
        logic [31:0] size;
        int          n_prog;
        logic [7:0]  prog [8];
        int          ferr_idx;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0]   tx_log [$];
    logic [W-1:0] wa_log [$];
    logic [31:0]  wd_log [$];
    logic [7:0]   rx_log [$];
    int           busy_cnt   = 0;
    bit           last_start = 1'b0;
    int           viol       = 0;
    int           ack_cnt    = 0;

    assign bus.tx_busy = (busy_cnt != 0);

    // UART_TX stand-in plus output logger, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt   = 0;
            last_start = 1'b0;
        end else begin
            if (bus.tx_start) begin
                tx_log.push_back(bus.tx_sdata);
                if (last_start || busy_cnt != 0) viol++;
            end
            if (busy_cnt != 0) busy_cnt--;
            if (bus.tx_start) busy_cnt = BUSY;
            last_start = bus.tx_start;
            if (bus.imem_we) begin
                wa_log.push_back(bus.imem_addr);
                wd_log.push_back(bus.imem_wdata);
            end
            if (bus.cpu_tx_ack) ack_cnt++;
            if (bus.cpu_rx_valid) rx_log.push_back(bus.cpu_rx_data);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic bit outs_nonzero();
        return |{bus.tx_sdata, bus.tx_start, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                 bus.boot_done, bus.boot_err, bus.cpu_tx_ack, bus.cpu_rx_valid, bus.cpu_rx_data};
    endfunction

    task automatic do_reset();
        reset_n            = 1'b0;
        bus.rx_rdata       = 8'h00;
        bus.rx_rdata_ready = 1'b0;
        bus.rx_ferr        = 1'b0;
        repeat (2) @(negedge clk);
        tx_log.delete();
        wa_log.delete();
        wd_log.delete();
        rx_log.delete();
        ack_cnt = 0;
        check("reset_outputs_zero", 32'(outs_nonzero()), 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ferr);
        bus.rx_rdata       = b;
        bus.rx_ferr        = ferr;
        bus.rx_rdata_ready = 1'b1;
        @(negedge clk);
        bus.rx_rdata_ready = 1'b0;
        bus.rx_ferr        = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        for (int i = 0; i < budget && tx_log.size() < n; i++) @(negedge clk);
        check(name, 32'(tx_log.size() >= n), 32'd1);
    endtask

    task automatic wait_ack(input int budget, input string name);
        for (int i = 0; i < budget && bus.cpu_tx_ack !== 1'b1; i++) @(negedge clk);
        check(name, 32'(bus.cpu_tx_ack), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] b;
        do_reset();
        wait_tx(1, 20, {v.name, "_wait_99"});
        for (int i = 0; i < 4 + v.n_prog; i++) begin
            b = (i < 4) ? v.size[8*i +: 8] : v.prog[i-4];
            send_byte(b, i == v.ferr_idx);
        end
        if (v.exp_done) wait_tx(2, 60, {v.name, "_wait_aa"});
        else repeat (30) @(negedge clk);
        repeat (2) @(negedge clk);
        check({v.name, "_boot_done"}, 32'(bus.boot_done), 32'(v.exp_done));
        check({v.name, "_boot_err"}, 32'(bus.boot_err), 32'(v.exp_err));
        check({v.name, "_writes"}, 32'(wa_log.size()), 32'(v.exp_writes));
        if (v.exp_writes >= 1 && wa_log.size() >= 1) begin
            check({v.name, "_addr0"}, 32'(wa_log[0]), 32'd0);
            check({v.name, "_data0"}, wd_log[0], v.exp_w0);
        end
        if (v.exp_writes >= 2 && wa_log.size() >= 2) begin
            check({v.name, "_addr1"}, 32'(wa_log[1]), 32'd1);
            check({v.name, "_data1"}, wd_log[1], v.exp_w1);
        end
        check({v.name, "_tx_count"}, 32'(tx_log.size()), v.exp_done ? 32'd2 : 32'd1);
        if (tx_log.size() >= 1) check({v.name, "_tx0"}, 32'(tx_log[0]), 32'h99);
        if (v.exp_done && tx_log.size() >= 2) check({v.name, "_tx1"}, 32'(tx_log[1]), 32'hAA);
        check({v.name, "_no_rx_fwd"}, 32'(rx_log.size()), 32'd0);
    endtask

    vec_t vecs [8];
    vec_t reboot;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"normal", 32'd8, 8, '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE},
                    -1, 1'b1, 1'b0, 2, 32'h12345678, 32'hDEADBEEF};
        vecs[1] = '{"empty", 32'd0, 0, '{default: 8'h00}, -1, 1'b1, 1'b0, 0, 32'd0, 32'd0};
        vecs[2] = '{"bad_size6", 32'd6, 0, '{default: 8'h00}, -1, 1'b0, 1'b1, 0, 32'd0, 32'd0};
        vecs[3] = '{"ferr_prog", 32'd8, 8, '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE},
                    6, 1'b0, 1'b1, 0, 32'd0, 32'd0};
        vecs[4] = '{"one_word", 32'd4, 4, '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h00, 8'h00, 8'h00, 8'h00},
                    -1, 1'b1, 1'b0, 1, 32'hCAFEF00D, 32'd0};
        vecs[5] = '{"too_big", 32'h00040004, 0, '{default: 8'h00}, -1, 1'b0, 1'b1, 0, 32'd0, 32'd0};
        vecs[6] = '{"max_size", 32'h00040000, 4, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00},
                    -1, 1'b0, 1'b0, 1, 32'h04030201, 32'd0};
        vecs[7] = '{"ferr_size", 32'd8, 0, '{default: 8'h00}, 1, 1'b0, 1'b1, 0, 32'd0, 32'd0};

        bus.cpu_tx_req  = 1'b0;
        bus.cpu_tx_data = 8'h00;

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Reset in the middle of the image: outputs clear at once, and the next boot starts clean.
        do_reset();
        wait_tx(1, 20, "midrst_wait_99");
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h78, 1'b0);
        #2 reset_n = 1'b0;
        #1 check("midrst_async_outputs_zero", 32'(outs_nonzero()), 32'd0);
        @(negedge clk);
        reboot      = vecs[0];
        reboot.name = "reboot";
        run_vec(reboot);

        // Core TX: request held from before boot must wait for RUN and for the AA transfer.
        bus.cpu_tx_req  = 1'b1;
        bus.cpu_tx_data = 8'h41;
        do_reset();
        wait_tx(1, 20, "run_wait_99");
        repeat (4) send_byte(8'h00, 1'b0);
        wait_ack(80, "run_ack_41");
        bus.cpu_tx_data = 8'h42;
        @(negedge clk);
        wait_ack(80, "run_ack_42");
        bus.cpu_tx_req = 1'b0;
        repeat (20) @(negedge clk);
        check("run_ack_count", 32'(ack_cnt), 32'd2);
        check("run_tx_count", 32'(tx_log.size()), 32'd4);
        if (tx_log.size() == 4) begin
            check("run_tx1_aa", 32'(tx_log[1]), 32'hAA);
            check("run_tx2_41", 32'(tx_log[2]), 32'h41);
            check("run_tx3_42", 32'(tx_log[3]), 32'h42);
        end
        check("tx_rule_violations", 32'(viol), 32'd0);

        // Core RX: the framing-error byte is dropped.
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (3) @(negedge clk);
        check("rx_fwd_count", 32'(rx_log.size()), 32'd2);
        if (rx_log.size() == 2) begin
            check("rx_fwd_0", 32'(rx_log[0]), 32'h31);
            check("rx_fwd_1", 32'(rx_log[1]), 32'h33);
        end
        check("run_still_done", 32'(bus.boot_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
